// File: rtl/fix_pkg.sv
// Shared types and ASCII constants for the FIX checksum-trailer checker.
package fix_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BODY = 3'd1,
    T1   = 3'd2,
    T0   = 3'd3,
    TEQ  = 3'd4,
    DIG  = 3'd5,
    TERM = 3'd6,
    CMP  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISMATCH = 2'b01,
    ERR_FORMAT   = 2'b10,
    ERR_LENGTH   = 2'b11
  } err_e;

  localparam logic [7:0] ASCII_SOH = 8'h01;
  localparam logic [7:0] ASCII_8   = 8'h38;
  localparam logic [7:0] ASCII_1   = 8'h31;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_EQ  = 8'h3D;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_csum_acc.sv
// Running mod-256 byte sum plus the snapshot taken at each candidate trailer SOH.
module fix_csum_acc
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic       snap,
  input  logic [7:0] data,
  output logic [7:0] snap_sum
);

  logic [7:0] sum_r;
  logic [7:0] snap_r;
  logic [7:0] sum_add_s;

  // clr restarts the sum, so a clr+add loads the new byte directly
  always_comb begin
    sum_add_s = (clr ? 8'h00 : sum_r) + data;
  end

  // Sum and snapshot registers; the snapshot includes the byte being added
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r  <= 8'h00;
      snap_r <= 8'h00;
    end else begin
      if (add) begin
        sum_r <= sum_add_s;
      end else if (clr) begin
        sum_r <= 8'h00;
      end else begin
        sum_r <= sum_r;
      end
      if (snap) begin
        snap_r <= sum_add_s;
      end else if (clr) begin
        snap_r <= 8'h00;
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  assign snap_sum = snap_r;

endmodule

// File: rtl/fix_csum_ctrl.sv
// FIX message checksum checker: finds SOH "10=ddd" SOH and compares against the byte sum.
// Optional statistics counters are built when FIX_CSUM_STATS_EN is defined.
module fix_csum_ctrl
  import fix_pkg::*;
#(
  parameter int MAX_MSG_LEN = 4096,
  parameter int LEN_W       = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        ok_o,
  output logic [1:0]  err_o,
  output logic [7:0]  csum_calc_o,
  output logic [7:0]  csum_rx_o,
  output logic [15:0] msg_cnt_o,
  output logic [15:0] err_cnt_o
);

  state_e            state_r, state_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [9:0]        value_r, value_s;
  logic [1:0]        dig_r, dig_s;
  logic              ready_r, done_r, ok_r;
  err_e              err_r;
  logic [7:0]        csum_calc_r, csum_rx_r;

  logic              accept_s, in_msg_s, len_hit_s;
  logic              acc_clr_s, acc_add_s, acc_snap_s;
  logic              fin_s, ok_s;
  err_e              err_s;
  logic [7:0]        snap_sum_s;

  assign accept_s  = valid_i && ready_r;
  assign in_msg_s  = (state_r != IDLE) && (state_r != TERM) && (state_r != CMP);
  assign len_hit_s = (len_r + LEN_W'(1)) == LEN_W'(MAX_MSG_LEN);

  fix_csum_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr_s),
    .add      (acc_add_s),
    .snap     (acc_snap_s),
    .data     (data_i),
    .snap_sum (snap_sum_s)
  );

  // Next-state, accumulator controls and completion decision
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    value_s    = value_r;
    dig_s      = dig_r;
    acc_clr_s  = 1'b0;
    acc_add_s  = 1'b0;
    acc_snap_s = 1'b0;
    fin_s      = 1'b0;
    ok_s       = 1'b0;
    err_s      = ERR_NONE;
    if (!accept_s) begin
      state_s = (state_r == CMP) ? IDLE : state_r;
    end else if (in_msg_s && len_hit_s) begin
      fin_s   = 1'b1;
      err_s   = ERR_LENGTH;
      state_s = IDLE;
    end else begin
      len_s     = len_r + LEN_W'(1);
      acc_add_s = (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (data_i == ASCII_8) begin
            state_s   = BODY;
            acc_clr_s = 1'b1;
            acc_add_s = 1'b1;
            len_s     = LEN_W'(1);
          end else begin
            len_s = len_r;
          end
        end
        BODY, T1, T0, TEQ: begin
          // SOH anywhere restarts the trailer match with a fresh snapshot
          if (data_i == ASCII_SOH) begin
            acc_snap_s = 1'b1;
            state_s    = T1;
          end else if (state_r == T1 && data_i == ASCII_1) begin
            state_s = T0;
          end else if (state_r == T0 && data_i == ASCII_0) begin
            state_s = TEQ;
          end else if (state_r == TEQ && data_i == ASCII_EQ) begin
            state_s = DIG;
            value_s = 10'd0;
            dig_s   = 2'd0;
          end else begin
            state_s = BODY;
          end
        end
        DIG: begin
          if (is_digit(data_i)) begin
            value_s = (value_r * 10'd10) + {6'd0, data_i[3:0]};
            dig_s   = dig_r + 2'd1;
            state_s = (dig_r == 2'd2) ? TERM : DIG;
          end else begin
            fin_s   = 1'b1;
            err_s   = ERR_FORMAT;
            state_s = IDLE;
          end
        end
        TERM: begin
          fin_s = 1'b1;
          if (data_i == ASCII_SOH && value_r <= 10'd255) begin
            ok_s    = (snap_sum_s == value_r[7:0]);
            err_s   = ok_s ? ERR_NONE : ERR_MISMATCH;
            state_s = CMP;
          end else begin
            err_s   = ERR_FORMAT;
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; result fields hold until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r       <= '0;
      value_r     <= 10'd0;
      dig_r       <= 2'd0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      ok_r        <= 1'b0;
      err_r       <= ERR_NONE;
      csum_calc_r <= 8'h00;
      csum_rx_r   <= 8'h00;
    end else begin
      len_r   <= len_s;
      value_r <= value_s;
      dig_r   <= dig_s;
      ready_r <= (state_s != CMP);
      done_r  <= fin_s;
      if (fin_s) begin
        ok_r        <= ok_s;
        err_r       <= err_s;
        csum_calc_r <= snap_sum_s;
        csum_rx_r   <= value_r[7:0];
      end else begin
        ok_r <= ok_r;
      end
    end
  end

  assign ready_o     = ready_r;
  assign done_o      = done_r;
  assign ok_o        = ok_r;
  assign err_o       = err_r;
  assign csum_calc_o = csum_calc_r;
  assign csum_rx_o   = csum_rx_r;

`ifdef FIX_CSUM_STATS_EN
  logic [15:0] msg_cnt_r, err_cnt_r;

  // Saturating message and error counters
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_cnt_r <= 16'h0000;
      err_cnt_r <= 16'h0000;
    end else begin
      if (done_r && msg_cnt_r != 16'hFFFF) begin
        msg_cnt_r <= msg_cnt_r + 16'd1;
      end else begin
        msg_cnt_r <= msg_cnt_r;
      end
      if (done_r && !ok_r && err_cnt_r != 16'hFFFF) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign msg_cnt_o = msg_cnt_r;
  assign err_cnt_o = err_cnt_r;
`else
  assign msg_cnt_o = 16'h0000;
  assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fix_csum_ctrl.sv
// Bench for fix_csum_ctrl: directed spec scenarios plus random streams against a message-level model.
module tb_fix_csum_ctrl;

  localparam int MAXL = 16;
`ifdef FIX_CSUM_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o, done_o, ok_o;
  logic [1:0]  err_o;
  logic [7:0]  csum_calc_o, csum_rx_o;
  logic [15:0] msg_cnt_o, err_cnt_o;

  fix_csum_ctrl #(.MAX_MSG_LEN(MAXL), .LEN_W(13)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .done_o(done_o), .ok_o(ok_o), .err_o(err_o), .csum_calc_o(csum_calc_o),
    .csum_rx_o(csum_rx_o), .msg_cnt_o(msg_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ev;
    bit       ok;
    bit [1:0] err;
    bit [7:0] calc;
    bit [7:0] rx;
    bit       chk_cs;
  } exp_t;

  logic [7:0] stim_q[$];
  exp_t       exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_msg = 0;
  int exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  task automatic blank_expect();
    exp_q.delete();
    for (int i = 0; i < stim_q.size(); i++) exp_q.push_back('{default: 0});
  endtask

  task automatic set_ev(input int idx, input bit ok, input bit [1:0] err,
                        input bit [7:0] calc, input bit [7:0] rx, input bit chk);
    exp_q[idx] = '{ev: 1'b1, ok: ok, err: err, calc: calc, rx: rx, chk_cs: chk};
  endtask

  // Message-level reference: locate '8', first SOH"10=", three digits, closing SOH, length cap.
  function automatic void build_expect();
    int n, i, start, k, e, lim, idx;
    int value;
    bit term, stop, ok;
    bit [1:0] err;
    logic [7:0] sum;
    n = stim_q.size();
    exp_q.delete();
    for (int j = 0; j < n; j++) exp_q.push_back('{default: 0});
    i = 0;
    while (i < n) begin
      if (stim_q[i] != 8'h38) begin
        i++;
        continue;
      end
      start = i; k = -1; e = n; term = 0; stop = 0; ok = 0; err = 2'd2; value = 0; sum = 8'h00;
      for (int p = start + 1; p + 3 < n; p++)
        if (k < 0 && stim_q[p] == 8'h01 && stim_q[p+1] == 8'h31 && stim_q[p+2] == 8'h30 && stim_q[p+3] == 8'h3D)
          k = p;
      if (k >= 0) begin
        for (int d = 0; d < 3; d++) begin
          idx = k + 4 + d;
          if (!stop) begin
            if (idx >= n) stop = 1;
            else if (stim_q[idx] < 8'h30 || stim_q[idx] > 8'h39) begin e = idx; stop = 1; end
            else value = value * 10 + int'(stim_q[idx] - 8'h30);
          end
        end
        if (!stop && k + 7 < n) begin
          e = k + 7;
          term = 1;
          if (stim_q[e] == 8'h01 && value <= 255) begin
            for (int j = start; j <= k; j++) sum = sum + stim_q[j];
            ok = (sum == value[7:0]);
            err = ok ? 2'd0 : 2'd1;
          end
        end
      end
      lim = start + MAXL - 1;
      if (lim < e || (lim == e && !term)) begin
        if (lim < n) exp_q[lim] = '{ev: 1'b1, ok: 1'b0, err: 2'd3, calc: 8'h00, rx: 8'h00, chk_cs: 1'b0};
        i = lim + 1;
      end else if (e < n) begin
        exp_q[e] = '{ev: 1'b1, ok: ok, err: err, calc: sum, rx: value[7:0], chk_cs: (term && err != 2'd2)};
        i = e + 1;
      end else begin
        i = n;
      end
    end
  endfunction

  task automatic idle_cycle();
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_done", done_o, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, output bit got);
    bit rdy;
    got = 1'b0;
    data_i = b;
    valid_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (!got) begin
        rdy = ready_o;
        @(posedge clk);
        @(negedge clk);
        got = rdy;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic run_stream(input bit gaps);
    bit got;
    for (int i = 0; i < stim_q.size(); i++) begin
      send(stim_q[i], got);
      check($sformatf("accept[%0d]", i), got, 1'b1);
      check($sformatf("done[%0d]", i), done_o, exp_q[i].ev);
      if (exp_q[i].ev) begin
        exp_msg++;
        if (!exp_q[i].ok) exp_err++;
        check($sformatf("ok[%0d]", i), ok_o, exp_q[i].ok);
        check($sformatf("err[%0d]", i), err_o, exp_q[i].err);
        check($sformatf("ready_after[%0d]", i), ready_o, !exp_q[i].chk_cs);
        if (exp_q[i].chk_cs) begin
          check($sformatf("calc[%0d]", i), csum_calc_o, exp_q[i].calc);
          check($sformatf("rx[%0d]", i), csum_rx_o, exp_q[i].rx);
        end
      end
      if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
    end
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_ok", ok_o, 1'b0);
    check("rst_err", err_o, 2'b00);
    check("rst_calc", csum_calc_o, 8'h00);
    check("rst_rx", csum_rx_o, 8'h00);
    check("rst_msg_cnt", msg_cnt_o, 16'h0000);
    check("rst_err_cnt", err_cnt_o, 16'h0000);
    rst = 1'b0;
    exp_msg = 0;
    exp_err = 0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_msg"}, msg_cnt_o, STATS_EN ? exp_msg : 0);
    check({tag, "_err"}, err_cnt_o, STATS_EN ? exp_err : 0);
  endtask

  logic [7:0] alpha [7] = '{8'h3D, 8'h41, 8'h31, 8'h30, 8'h01, 8'h39, 8'h5A};
  logic [7:0] junk  [4] = '{8'h41, 8'h01, 8'h31, 8'h3D};

  initial begin
    logic [7:0] sum;
    int value;
    @(negedge clk);
    do_reset();

    // good checksum, then mismatch
    push_str("8=A"); stim_q.push_back(8'h01); push_str("10=183"); stim_q.push_back(8'h01);
    blank_expect(); set_ev(10, 1'b1, 2'b00, 8'hB7, 8'hB7, 1'b1); run_stream(1'b0);
    push_str("8=A"); stim_q.push_back(8'h01); push_str("10=184"); stim_q.push_back(8'h01);
    blank_expect(); set_ev(10, 1'b0, 2'b01, 8'hB7, 8'hB8, 1'b1); run_stream(1'b0);
    idle_cycle();
    idle_cycle();
    check("stats_pair_msg", msg_cnt_o, STATS_EN ? 16'd2 : 16'd0);
    check("stats_pair_err", err_cnt_o, STATS_EN ? 16'd1 : 16'd0);

    // non-digit in trailer, then out-of-range value
    push_str("8=A"); stim_q.push_back(8'h01); push_str("10=1A3");
    blank_expect(); set_ev(8, 1'b0, 2'b10, 8'h00, 8'h00, 1'b0); run_stream(1'b0);
    push_str("8=A"); stim_q.push_back(8'h01); push_str("10=300"); stim_q.push_back(8'h01);
    blank_expect(); set_ev(10, 1'b0, 2'b10, 8'h00, 8'h00, 1'b0); run_stream(1'b0);

    // "110=" inside body must not start the trailer
    push_str("8110=5"); stim_q.push_back(8'h01); push_str("10=061"); stim_q.push_back(8'h01);
    blank_expect(); set_ev(13, 1'b1, 2'b00, 8'h3D, 8'h3D, 1'b1); run_stream(1'b1);

    // length overflow at the 16th byte, then a clean message
    stim_q.push_back(8'h38);
    repeat (19) stim_q.push_back(8'h42);
    push_str("8=A"); stim_q.push_back(8'h01); push_str("10=183"); stim_q.push_back(8'h01);
    blank_expect();
    set_ev(15, 1'b0, 2'b11, 8'h00, 8'h00, 1'b0);
    set_ev(30, 1'b1, 2'b00, 8'hB7, 8'hB7, 1'b1);
    run_stream(1'b0);

    // reset mid-body, then a full message
    push_str("8=A");
    blank_expect(); run_stream(1'b0);
    do_reset();
    push_str("8=A"); stim_q.push_back(8'h01); push_str("10=183"); stim_q.push_back(8'h01);
    blank_expect(); set_ev(10, 1'b1, 2'b00, 8'hB7, 8'hB7, 1'b1); run_stream(1'b0);

    // randomized messages checked against the reference model
    repeat (60) begin
      repeat ($urandom_range(0, 2)) stim_q.push_back(junk[$urandom_range(0, 3)]);
      stim_q.push_back(8'h38);
      sum = 8'h38;
      repeat ($urandom_range(0, 8)) begin
        stim_q.push_back(alpha[$urandom_range(0, 6)]);
        sum = sum + stim_q[stim_q.size() - 1];
      end
      sum = sum + 8'h01;
      stim_q.push_back(8'h01); push_str("10=");
      value = ($urandom_range(0, 1) == 1) ? int'(sum) : int'($urandom_range(0, 999));
      stim_q.push_back(8'(8'h30 + value / 100));
      stim_q.push_back(($urandom_range(0, 7) == 0) ? 8'h78 : 8'(8'h30 + (value / 10) % 10));
      stim_q.push_back(8'(8'h30 + value % 10));
      stim_q.push_back(($urandom_range(0, 7) == 0) ? 8'h5A : 8'h01);
    end
    build_expect();
    run_stream(1'b1);
    idle_cycle();
    idle_cycle();
    check_stats("stats_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fix_csum_ctrl.md
FIX_CSUM_CTRL -- requirements
Module: fix_csum_ctrl

Interface
REQ-001 SHALL have parameter MAX_MSG_LEN, default 4096, max bytes per message counted from the leading '8' inclusive.
REQ-002 SHALL have parameter LEN_W, default 13, width of the length counter.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_i  input  8  received byte.
REQ-006 valid_i  input  1  data_i valid; a byte is accepted when valid_i && ready_o.
REQ-007 ready_o  output  1  byte accept enable.
REQ-008 done_o  output  1  one-cycle pulse: message complete or aborted.
REQ-009 ok_o  output  1  qualified by done_o; 1 = checksum matched.
REQ-010 err_o  output  2  qualified by done_o: 00 none, 01 mismatch, 10 format, 11 length overflow.
REQ-011 csum_calc_o  output  8  computed checksum, held from done_o until the next done_o.
REQ-012 csum_rx_o  output  8  received trailer value, held likewise.
REQ-013 msg_cnt_o / err_cnt_o  output  16 each  statistics counters (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, BODY, T1, T0, TEQ, DIG, TERM, CMP.
REQ-015 IDLE: accepted byte 0x38 ('8') -> BODY, clear sum, sum := 0x38, len := 1; other bytes discarded.
REQ-016 BODY: every accepted byte added to running sum (8-bit, mod 256 wrap); on SOH (0x01), snap := sum including that SOH, -> T1.
REQ-017 T1: byte '1' -> T0; SOH -> re-snap, stay T1; other -> BODY. All bytes still summed.
REQ-018 T0: '0' -> TEQ; TEQ: '=' -> DIG (digit index 0); any mismatch -> BODY (SOH -> T1 with re-snap).
REQ-019 DIG: exactly 3 ASCII digits 0x30-0x39, value := value*10 + digit, 10-bit accumulator; non-digit -> abort err 10.
REQ-020 TERM: SOH -> CMP; any other byte -> abort err 10; value > 255 -> abort err 10 at this byte.
REQ-021 CMP: ready_o=0; done_o=1, ok_o=(snap==value), err_o=01 on mismatch; -> IDLE next cycle.
REQ-022 Latency: done_o asserted exactly 1 cycle after the terminating SOH is accepted.
REQ-023 ready_o SHALL be 1 in every state except CMP; bytes with valid_i=0 change nothing.
REQ-024 Length: len increments per accepted byte; if len reaches MAX_MSG_LEN in any state before TERM completes, abort err 11.
REQ-025 Abort: done_o pulse the next cycle with ok_o=0, csum outputs updated, FSM -> IDLE; the aborting byte is not re-parsed.
REQ-026 "10=" not preceded by SOH (e.g. "110=") SHALL NOT trigger the trailer.

Reset
REQ-027 rst wins over every other event, including mid-message and during CMP.
REQ-028 Reset values: state IDLE, ready_o 1, done_o 0, ok_o 0, err_o 00, csum_calc_o 0, csum_rx_o 0, counters 0, len 0, sum 0.

Configuration
REQ-029 FIX_CSUM_STATS_EN defined: msg_cnt_o increments on every done_o, err_cnt_o on done_o with ok_o=0; both saturate at 0xFFFF.
REQ-030 FIX_CSUM_STATS_EN undefined: counters not built; msg_cnt_o and err_cnt_o tied to 0; all other behaviour identical.

Structure
REQ-031 Package fix_pkg SHALL hold state enum, 2-bit error-code typedef, ASCII constants SOH 0x01, '8' 0x38, '1' 0x31, '0' 0x30, '=' 0x3D.
REQ-032 Sub-module fix_csum_acc SHALL hold the 8-bit running sum and snapshot register (clear/add/snap controls); the FSM stays in fix_csum_ctrl.

Verification
REQ-033 Bytes "8=A",01,"10=183",01 -> done_o 1 cycle after last SOH, ok_o=1, err_o=00, csum_calc_o=0xB7, csum_rx_o=0xB7.
REQ-034 Same message with trailer "10=184" -> ok_o=0, err_o=01, csum_calc_o=0xB7, csum_rx_o=0xB8.
REQ-035 Trailer "10=1A3" -> abort err_o=10 one cycle after 'A'; trailer "10=300",01 -> err_o=10.
REQ-036 MAX_MSG_LEN=16, '8' followed by 19 non-SOH bytes -> err_o=11 one cycle after the 16th byte; following "8=A",01,"10=183",01 passes.
REQ-037 rst asserted mid-BODY, then valid message -> no done_o for aborted message; new message ok_o=1.
REQ-038 With FIX_CSUM_STATS_EN: one pass, one mismatch -> msg_cnt_o=2, err_cnt_o=1; without macro both remain 0.
